// File: rtl/disp7seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment word layout is {g,f,e,d,c,b,a}, active-high, identical to the
// single-digit decoders elsewhere on the board.
package disp7seg_pkg;

   typedef logic [6:0] seg7_t;

   // All segments off; used for reset and for blanked leading zeros.
   localparam seg7_t SEG_BLANK = 7'b0000000;

   // Hex glyphs 0..F, index = nibble value.
   localparam seg7_t HEX7_TABLE [16] = '{
      7'b0111111,   // 0
      7'b0000110,   // 1
      7'b1011011,   // 2
      7'b1001111,   // 3
      7'b1100110,   // 4
      7'b1101101,   // 5
      7'b1111101,   // 6
      7'b0000111,   // 7
      7'b1111111,   // 8
      7'b1101111,   // 9
      7'b1110111,   // A
      7'b1111100,   // b
      7'b0111001,   // C
      7'b1011110,   // d
      7'b1111001,   // E
      7'b1110001    // F
   };

   // Counter width helper: at least one bit even when the range is a single value.
   function automatic int unsigned width_min1(input int unsigned range_v);
      int unsigned w;
      if (range_v > 32'd1) begin
         w = $clog2(range_v);
      end else begin
         w = 32'd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/disp7seg_hex7seg.sv
// Combinational hex-to-7-segment decoder, pure table lookup.
module hex7seg
   import disp7seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Look up the glyph for the incoming nibble.
   always_comb begin
      seg = HEX7_TABLE[nib];
   end

endmodule

// File: rtl/disp7seg_scan.sv
// Multiplexed N-digit 7-segment display driver.
// A frame (one hex nibble per digit, digit 0 rightmost) is taken through a
// valid/ready handshake into a shadow register and copied to the displayed
// frame only at scan wrap, so a frame is never shown half old / half new.
// Optional build macro DISP7SEG_LZ_BLANK_EN: blank leading-zero digits
// (digit 0 is always shown). Without it every digit is decoded.
module disp7seg_scan
   import disp7seg_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int CLK_DIV  = 50000
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*N_DIGITS-1:0]   in_data,
   output logic [N_DIGITS-1:0]     an,
   output logic [6:0]              seg,
   output logic                    frame_done
);

   localparam int FRAME_W = 4 * N_DIGITS;
   localparam int CNT_W   = int'(width_min1(CLK_DIV));
   localparam int IDX_W   = int'(width_min1(N_DIGITS));

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   // Registered state
   logic [CNT_W-1:0]    cnt_q,        cnt_d;
   logic [IDX_W-1:0]    idx_q,        idx_d;
   logic [FRAME_W-1:0]  shadow_q,     shadow_d;
   logic [FRAME_W-1:0]  active_q,     active_d;
   logic                pending_q,    pending_d;
   logic [N_DIGITS-1:0] an_q,         an_d;
   logic [6:0]          seg_q,        seg_d;
   logic                frame_done_q, frame_done_d;

   // Combinational helpers
   logic                tick_s;
   logic                wrap_s;
   logic                accept_s;
   logic [3:0]          nibble_s;
   logic [6:0]          dec_seg_s;
   logic                blank_s;

   // Dwell tick, end-of-scan wrap and handshake acceptance.
   always_comb begin
      tick_s   = (cnt_q == CNT_LAST);
      wrap_s   = tick_s && (idx_q == IDX_LAST);
      accept_s = in_valid && !pending_q;
   end

   // Divider counts one dwell; the digit index advances on each tick.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (tick_s) begin
         cnt_d = {CNT_W{1'b0}};
         if (idx_q == IDX_LAST) begin
            idx_d = {IDX_W{1'b0}};
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Frame path: commit shadow at wrap, otherwise capture an accepted frame.
   // Accept needs pending=0 and commit needs pending=1, so they never collide;
   // a frame accepted on the wrap cycle waits for the following wrap.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (wrap_s && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end else if (accept_s) begin
         shadow_d  = in_data;
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   // Select the nibble of the displayed frame for the current digit (AND-OR mux).
   always_comb begin
      nibble_s = 4'h0;
      for (int k = 0; k < N_DIGITS; k++) begin
         nibble_s = nibble_s | ({4{idx_q == IDX_W'(k)}} & active_q[4*k +: 4]);
      end
   end

   hex7seg u_hex7seg (
      .nib (nibble_s),
      .seg (dec_seg_s)
   );

`ifdef DISP7SEG_LZ_BLANK_EN
   logic [N_DIGITS-1:0] upper_zero_s;

   // upper_zero_s[k] is set when nibbles N_DIGITS-1..k are all zero; a
   // nonzero digit position k>0 is blanked exactly then.
   always_comb begin
      logic run;
      run          = 1'b1;
      upper_zero_s = {N_DIGITS{1'b0}};
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         run             = run & (active_q[4*k +: 4] == 4'h0);
         upper_zero_s[k] = run;
      end
      blank_s = 1'b0;
      for (int k = 1; k < N_DIGITS; k++) begin
         blank_s = blank_s | ((idx_q == IDX_W'(k)) & upper_zero_s[k]);
      end
   end
`else
   // Leading-zero blanking not built: every digit is decoded.
   always_comb begin
      blank_s = 1'b0;
   end
`endif

   // Next values of the registered pins: one-hot anode, glyph, wrap pulse.
   always_comb begin
      an_d = {N_DIGITS{1'b0}};
      for (int k = 0; k < N_DIGITS; k++) begin
         an_d[k] = (idx_q == IDX_W'(k));
      end
      if (blank_s) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = dec_seg_s;
      end
      frame_done_d = wrap_s;
   end

   // State and output registers with synchronous reset; reset drops any pending frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= {CNT_W{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         shadow_q     <= {FRAME_W{1'b0}};
         active_q     <= {FRAME_W{1'b0}};
         pending_q    <= 1'b0;
         an_q         <= {N_DIGITS{1'b0}};
         seg_q        <= SEG_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign in_ready   = !pending_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp7seg_scan.sv
// Self-checking bench for disp7seg_scan (N_DIGITS=4, CLK_DIV=4).
// Reference model works from elapsed cycles since reset: digit = (t/DIV)%N,
// wrap when t%(N*DIV) is the last cycle of a scan.
module tb_disp7seg_scan;

   localparam int N    = 4;
   localparam int DIV  = 4;
   localparam int SCAN = N * DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_done;

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model state
   int          m_t;
   logic [15:0] m_shadow, m_active;
   bit          m_pending;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_fd, exp_ready;

   disp7seg_scan #(.N_DIGITS(N), .CLK_DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_seg(input logic [15:0] frame, input int d);
      int upper;
      upper = int'(frame) >> (4 * d);
`ifdef DISP7SEG_LZ_BLANK_EN
      if (d > 0 && upper == 0) return 7'b0000000;
`endif
      case (upper % 16)
         0: return 7'b0111111;   1: return 7'b0000110;
         2: return 7'b1011011;   3: return 7'b1001111;
         4: return 7'b1100110;   5: return 7'b1101101;
         6: return 7'b1111101;   7: return 7'b0000111;
         8: return 7'b1111111;   9: return 7'b1101111;
         10: return 7'b1110111;  11: return 7'b1111100;
         12: return 7'b0111001;  13: return 7'b1011110;
         14: return 7'b1111001;  15: return 7'b1110001;
         default: return 7'b0000000;
      endcase
   endfunction

   // advance one clock edge, predicting what the DUT shows after it
   task automatic cycle();
      int d;
      bit wrap, acc;
      d    = (m_t / DIV) % N;
      wrap = (m_t % SCAN) == SCAN - 1;
      acc  = in_valid && !m_pending;
      if (reset) begin
         m_t = 0; m_shadow = 16'h0; m_active = 16'h0; m_pending = 0;
         exp_an = 4'b0; exp_seg = 7'b0; exp_fd = 1'b0; exp_ready = 1'b1;
      end else begin
         exp_an  = 4'(1 << d);
         exp_seg = ref_seg(m_active, d);
         exp_fd  = wrap;
         if (wrap && m_pending) begin
            m_active = m_shadow; m_pending = 0;
         end else if (acc) begin
            m_shadow = in_data; m_pending = 1;
         end
         exp_ready = !m_pending;
         m_t++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = 16'h0;
      repeat (3) cycle();
      tests_run++;
      if ({an, seg, frame_done, in_ready} !== {4'b0, 7'b0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_state: got an=%b seg=%b fd=%b rdy=%b, want 0000 0000000 0 1", an, seg, frame_done, in_ready);
      end
      reset = 1'b0;
      cycle();
      tests_run++;
      if ({an, seg, frame_done, in_ready} !== {4'b0001, 7'b0111111, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL first_scan: got an=%b seg=%b fd=%b rdy=%b, want 0001 0111111 0 1", an, seg, frame_done, in_ready);
      end
   endtask

   task automatic test_load();
      int c0, c1, c2, c3;
      in_valid = 1'b1; in_data = 16'h1234;
      cycle();
      in_valid = 1'b0; in_data = 16'(($urandom));
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_ready_low: got %b want 0", in_ready);
      end
      for (int i = 0; i < 20 && !in_ready; i++) begin
         cycle();
         tests_run++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_ready}) begin
            tests_failed++;
            $display("FAIL load_wait: got %b %b %b %b want %b %b %b %b", an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_ready);
         end
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_commit_timeout: in_ready=%b want 1", in_ready);
      end
      c0 = 0; c1 = 0; c2 = 0; c3 = 0;
      repeat (SCAN) begin
         cycle();
         if (an === 4'b0001 && seg === 7'b1100110) c0++;
         if (an === 4'b0010 && seg === 7'b1001111) c1++;
         if (an === 4'b0100 && seg === 7'b1011011) c2++;
         if (an === 4'b1000 && seg === 7'b0000110) c3++;
      end
      tests_run++;
      if ({c0, c1, c2, c3} !== {32'd4, 32'd4, 32'd4, 32'd4}) begin
         tests_failed++;
         $display("FAIL load_1234_digits: got counts %0d %0d %0d %0d want 4 4 4 4", c0, c1, c2, c3);
      end
   endtask

   task automatic test_reject_and_wrap();
      int cd;
      in_valid = 1'b1; in_data = 16'h5555;
      cycle();
      in_data = 16'h9999;
      repeat (3) begin
         cycle();
         tests_run++;
         if (in_ready !== 1'b0 || {an, seg} !== {exp_an, exp_seg}) begin
            tests_failed++;
            $display("FAIL reject_pending: got rdy=%b an=%b seg=%b want 0 %b %b", in_ready, an, seg, exp_an, exp_seg);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !((m_t % SCAN) == SCAN - 1 && !m_pending); i++) begin
         cycle();
         tests_run++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_ready}) begin
            tests_failed++;
            $display("FAIL reject_wait: got %b %b %b %b want %b %b %b %b", an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_ready);
         end
      end
      in_valid = 1'b1; in_data = 16'hABCD;
      cycle();
      in_valid = 1'b0;
      tests_run++;
      if (in_ready !== 1'b0 || frame_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_accept: got rdy=%b fd=%b want 0 1", in_ready, frame_done);
      end
      cd = 0;
      repeat (2 * SCAN) begin
         cycle();
         if (an === 4'b0001 && seg === 7'b1011110) cd++;
         tests_run++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_ready}) begin
            tests_failed++;
            $display("FAIL wrap_commit: got %b %b %b %b want %b %b %b %b", an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_ready);
         end
      end
      tests_run++;
      if (cd !== 4) begin
         tests_failed++;
         $display("FAIL abcd_digit0: got %0d cycles showing d, want 4", cd);
      end
   endtask

   task automatic test_frame_done();
      int pulses, wide;
      logic prev;
      pulses = 0; wide = 0; prev = frame_done;
      in_valid = 1'b0;
      repeat (5 * SCAN) begin
         cycle();
         if (frame_done === 1'b1) pulses++;
         if (frame_done === 1'b1 && prev === 1'b1) wide++;
         prev = frame_done;
      end
      tests_run++;
      if (pulses !== 5 || wide !== 0) begin
         tests_failed++;
         $display("FAIL frame_done_rate: got pulses=%0d wide=%0d want 5 0", pulses, wide);
      end
   endtask

   task automatic test_reset_midscan();
      int seen_e;
      for (int i = 0; i < 40 && (m_t % SCAN) != 2; i++) cycle();
      in_valid = 1'b1; in_data = 16'hEEEE;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      tests_run++;
      if ({an, seg, frame_done, in_ready} !== {4'b0, 7'b0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL midscan_reset: got an=%b seg=%b fd=%b rdy=%b want 0000 0000000 0 1", an, seg, frame_done, in_ready);
      end
      seen_e = 0;
      repeat (3 * SCAN) begin
         cycle();
         if (seg === 7'b1111001) seen_e++;
         tests_run++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_ready}) begin
            tests_failed++;
            $display("FAIL after_reset: got %b %b %b %b want %b %b %b %b", an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_ready);
         end
      end
      tests_run++;
      if (seen_e !== 0) begin
         tests_failed++;
         $display("FAIL discarded_frame: got %0d cycles of E, want 0", seen_e);
      end
   endtask

   task automatic test_leading_zero();
      int c3, c1, c0;
      logic [6:0] want3;
`ifdef DISP7SEG_LZ_BLANK_EN
      want3 = 7'b0000000;
`else
      want3 = 7'b0111111;
`endif
      in_valid = 1'b1; in_data = 16'h0070;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !in_ready; i++) cycle();
      c3 = 0; c1 = 0; c0 = 0;
      repeat (SCAN) begin
         cycle();
         if (an === 4'b1000 && seg === want3) c3++;
         if (an === 4'b0010 && seg === 7'b0000111) c1++;
         if (an === 4'b0001 && seg === 7'b0111111) c0++;
      end
      tests_run++;
      if ({c3, c1, c0} !== {32'd4, 32'd4, 32'd4}) begin
         tests_failed++;
         $display("FAIL lz_0070: got counts d3=%0d d1=%0d d0=%0d want 4 4 4", c3, c1, c0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         in_valid = ($urandom_range(0, 3) == 0);
         in_data  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         reset    = ($urandom_range(0, 149) == 0);
         cycle();
         tests_run++;
         if ({an, seg, frame_done, in_ready} !== {exp_an, exp_seg, exp_fd, exp_ready}) begin
            tests_failed++;
            $display("FAIL random[%0d]: got %b %b %b %b want %b %b %b %b", i, an, seg, frame_done, in_ready, exp_an, exp_seg, exp_fd, exp_ready);
         end
      end
      reset = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      m_t = 0; m_shadow = 16'h0; m_active = 16'h0; m_pending = 0;
      test_reset();
      test_load();
      test_reject_and_wrap();
      test_frame_done();
      test_reset_midscan();
      test_leading_zero();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
